// File: rtl/shapool_pkg.sv
// Shared definitions for the shapool job controller: FSM states and nonce pipeline constants.
// Imported by the controller top and the flag encoder.
package shapool_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } jobState_t;

    // The pool's reported nonce runs this many 64-cycle rounds ahead of the hashed one.
    localparam int NONCE_PIPE_DEPTH = 2;
    localparam int NONCE_W          = 32;
    localparam int PHASE_W          = 6;
    localparam int FLAGS_W          = 8;

    function automatic logic [NONCE_W-1:0] rewindNonce(input logic [NONCE_W-1:0] nonce);
        return nonce - NONCE_W'(NONCE_PIPE_DEPTH);
    endfunction

endpackage

// File: rtl/shapool_job_ctrl_if.sv
// Host/pool bundle between the job controller and its surroundings.
// The master side is the host plus the hash pool; the slave side is the controller.
interface shapool_job_ctrl_if;

    logic         job_valid;
    logic         job_ready;
    logic [255:0] job_sha_state;
    logic [95:0]  job_message_head;
    logic [7:0]   job_nonce_start_msb;
    logic         cancel;
    logic         busy;

    logic         result_valid;
    logic         result_ready;
    logic         result_found;
    logic [31:0]  result_nonce;
    logic [7:0]   result_flags;

    logic         pool_reset_n;
    logic [255:0] pool_sha_state;
    logic [95:0]  pool_message_head;
    logic [7:0]   pool_nonce_start_msb;
    logic         pool_success;
    logic [31:0]  pool_nonce;
    logic [7:0]   pool_match_flags;

    modport master (
        output job_valid,
        output job_sha_state,
        output job_message_head,
        output job_nonce_start_msb,
        output cancel,
        output result_ready,
        output pool_success,
        output pool_nonce,
        output pool_match_flags,
        input  job_ready,
        input  busy,
        input  result_valid,
        input  result_found,
        input  result_nonce,
        input  result_flags,
        input  pool_reset_n,
        input  pool_sha_state,
        input  pool_message_head,
        input  pool_nonce_start_msb
    );

    modport slave (
        input  job_valid,
        input  job_sha_state,
        input  job_message_head,
        input  job_nonce_start_msb,
        input  cancel,
        input  result_ready,
        input  pool_success,
        input  pool_nonce,
        input  pool_match_flags,
        output job_ready,
        output busy,
        output result_valid,
        output result_found,
        output result_nonce,
        output result_flags,
        output pool_reset_n,
        output pool_sha_state,
        output pool_message_head,
        output pool_nonce_start_msb
    );

endinterface

// File: rtl/shapool_flag_encoder.sv
// Combinational priority encoder: index of the lowest set match flag (0 when none is set).
module shapool_flag_encoder
    import shapool_pkg::*;
#(
    parameter int unsigned POOL_SIZE = 2,
    parameter int unsigned INDEX_W   = 1
) (
    input  logic [POOL_SIZE-1:0] i_flags,
    output logic [INDEX_W-1:0]   o_index
);

    // Scanning downward lets the lowest set flag overwrite any higher one.
    always_comb begin
        o_index = '0;
        for (int i = POOL_SIZE - 1; i >= 0; i--) begin
            if (i_flags[i]) begin
                o_index = INDEX_W'(i);
            end
        end
    end

endmodule

// File: rtl/shapool_job_ctrl.sv
// Job controller for a shapool hash pool: loads a job, runs the pool, and reports either a
// golden nonce (rewound past the pool pipeline) or exhaustion of the nonce segment.
module shapool_job_ctrl
    import shapool_pkg::*;
#(
    parameter int unsigned POOL_SIZE      = 2,
    parameter int unsigned POOL_SIZE_LOG2 = 1,
    parameter int unsigned INTERVAL_LIMIT = (32'd1 << (32 - POOL_SIZE_LOG2)) + 32'd1
) (
    input  logic              clk,
    input  logic              reset_n,
    shapool_job_ctrl_if.slave bus
);

    localparam int          LOW_W    = NONCE_W - POOL_SIZE_LOG2;
    localparam logic [31:0] LOW_MASK = 32'hFFFF_FFFF >> POOL_SIZE_LOG2;

    jobState_t                   r_state;
    jobState_t                   w_nextState;

    logic [PHASE_W-1:0]          r_phase;
    logic [31:0]                 r_intervalCnt;

    logic [255:0]                r_shaState;
    logic [95:0]                 r_messageHead;
    logic [7:0]                  r_nonceStartMsb;

    logic                        r_resultFound;
    logic [NONCE_W-1:0]          r_resultNonce;
    logic [FLAGS_W-1:0]          r_resultFlags;

    logic [POOL_SIZE_LOG2-1:0]   w_poolIndex;
    logic [NONCE_W-1:0]          w_rewoundNonce;
    logic [NONCE_W-1:0]          w_mixedNonce;
    logic [NONCE_W-1:0]          w_goldenNonce;
    logic                        w_jobAccept;
    logic                        w_intervalEnd;
    logic                        w_exhausted;
    logic                        w_captureSuccess;
    logic                        w_captureExhaust;

    shapool_flag_encoder #(
        .POOL_SIZE (POOL_SIZE),
        .INDEX_W   (POOL_SIZE_LOG2)
    ) u_flagEncoder (
        .i_flags (bus.pool_match_flags[POOL_SIZE-1:0]),
        .o_index (w_poolIndex)
    );

    // The start segment is folded into bits [31:24] of the rewound word before the
    // pipeline index replaces the top POOL_SIZE_LOG2 bits.
    assign w_rewoundNonce = rewindNonce(bus.pool_nonce);
    assign w_mixedNonce   = w_rewoundNonce ^ {r_nonceStartMsb, 24'd0};
    assign w_goldenNonce  = (w_mixedNonce & LOW_MASK) | {w_poolIndex, {LOW_W{1'b0}}};

    assign w_jobAccept      = (r_state == IDLE) && bus.job_valid;
    assign w_intervalEnd    = (r_phase == '1);
    assign w_exhausted      = w_intervalEnd && (r_intervalCnt == INTERVAL_LIMIT - 32'd1);
    assign w_captureSuccess = (r_state == RUN) && !bus.cancel && bus.pool_success;
    assign w_captureExhaust = (r_state == RUN) && !bus.cancel && !bus.pool_success && w_exhausted;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (bus.job_valid) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_nextState = bus.cancel ? IDLE : RUN;
            end
            RUN: begin
                if (bus.cancel) begin
                    w_nextState = IDLE;
                end else if (bus.pool_success || w_exhausted) begin
                    w_nextState = REPORT;
                end
            end
            REPORT: begin
                if (bus.result_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shaState      <= '0;
            r_messageHead   <= '0;
            r_nonceStartMsb <= '0;
        end else if (w_jobAccept) begin
            r_shaState      <= bus.job_sha_state;
            r_messageHead   <= bus.job_message_head;
            r_nonceStartMsb <= bus.job_nonce_start_msb;
        end
    end

    // Phase follows the pool's 64-cycle round; it is zero on the first RUN cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase       <= '0;
            r_intervalCnt <= '0;
        end else if (r_state == LOAD) begin
            r_phase       <= '0;
            r_intervalCnt <= '0;
        end else if (r_state == RUN) begin
            r_phase <= r_phase + PHASE_W'(1);
            if (w_intervalEnd) begin
                r_intervalCnt <= r_intervalCnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resultFound <= 1'b0;
            r_resultNonce <= '0;
            r_resultFlags <= '0;
        end else if (w_captureSuccess) begin
            r_resultFound <= 1'b1;
            r_resultNonce <= w_goldenNonce;
            r_resultFlags <= bus.pool_match_flags;
        end else if (w_captureExhaust) begin
            r_resultFound <= 1'b0;
            r_resultNonce <= '0;
            r_resultFlags <= '0;
        end
    end

    assign bus.job_ready            = (r_state == IDLE);
    assign bus.busy                 = (r_state != IDLE);
    assign bus.result_valid         = (r_state == REPORT);
    assign bus.result_found         = r_resultFound;
    assign bus.result_nonce         = r_resultNonce;
    assign bus.result_flags         = r_resultFlags;
    assign bus.pool_reset_n         = (r_state == RUN);
    assign bus.pool_sha_state       = r_shaState;
    assign bus.pool_message_head    = r_messageHead;
    assign bus.pool_nonce_start_msb = r_nonceStartMsb;

endmodule
